// File: rtl/imem_fetch.sv
// Instruction memory fetch port: valid/ready request/response with programmable read
// latency, alignment/range error reporting, flush for redirects and a program-load port.
module imem_fetch #(
  parameter  int XLEN    = 32,
  parameter  int DEPTH   = 16,
  parameter  int LATENCY = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic [XLEN-1:0] rsp_addr,
  output logic [1:0]      rsp_err,
  input  logic            flush,
  input  logic            ld_en,
  input  logic [AW-1:0]   ld_addr,
  input  logic [XLEN-1:0] ld_data
);

  localparam int          CW       = 4;
  localparam logic [CW-1:0] CNT_INIT = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;
  localparam logic [31:0] DEPTH_U  = 32'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [XLEN-1:0] r_mem [DEPTH];
  logic            r_vld;
  logic [XLEN-1:0] r_rsp_data, r_rsp_addr;
  logic [1:0]      r_rsp_err;

  logic            w_acc, w_mis, w_oor, w_good_hit, w_load_data;
  logic [1:0]      w_err;
  logic [AW-1:0]   w_rd_idx;
  logic [XLEN-1:0] w_rd_data;

  // Storage is deliberately not reset; program contents survive rst_n.
  always_ff @(posedge clk) begin
    if (ld_en && (32'(ld_addr) < DEPTH_U))
      r_mem[ld_addr] <= ld_data;
  end

  assign req_ready = !flush && ((r_state == IDLE) || ((r_state == RESP) && rsp_ready));
  assign w_acc     = req_valid && req_ready;

  assign w_mis = |req_addr[1:0];
  assign w_oor = (req_addr >> 2) >= XLEN'(DEPTH);
  assign w_err = {w_oor, w_mis};

  // In WAIT the request is gone, so the word index comes from the captured address.
  assign w_rd_idx  = (r_state == WAIT) ? r_rsp_addr[AW+1:2] : req_addr[AW+1:2];
  assign w_rd_data = r_mem[w_rd_idx];

  assign w_good_hit  = w_acc && (w_err == 2'b00) && (LATENCY == 1);
  assign w_load_data = !flush && (w_good_hit || ((r_state == WAIT) && (r_cnt == '0)));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (flush) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: ;
        WAIT: begin
          if (r_cnt == '0) w_state_nxt = RESP;
          else             w_cnt_nxt   = r_cnt - 1'b1;
        end
        RESP:    if (rsp_ready) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
      if (w_acc) begin
        if ((w_err != 2'b00) || (LATENCY == 1)) begin
          w_state_nxt = RESP;
        end else begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = CNT_INIT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Response registers; a same-edge load returns the pre-write word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld      <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_addr <= '0;
      r_rsp_err  <= '0;
    end else begin
      r_vld <= (w_state_nxt == RESP);
      if (w_acc) begin
        r_rsp_addr <= req_addr;
        r_rsp_err  <= w_err;
      end
      if (w_acc && (w_err != 2'b00)) r_rsp_data <= '0;
      else if (w_load_data)          r_rsp_data <= w_rd_data;
    end
  end

  assign rsp_valid = r_vld;
  assign rsp_data  = r_rsp_data;
  assign rsp_addr  = r_rsp_addr;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_imem_fetch.sv
// Scoreboard bench for imem_fetch: three instances (LATENCY 1, 3, 4) share the load port;
// stimulus pushes expected responses, per-instance monitors pop and compare.
module tb_imem_fetch;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid, req_ready, rsp_valid, rsp_ready, flush;
  logic [31:0] req_addr [3];
  logic [31:0] rsp_data [3];
  logic [31:0] rsp_addr [3];
  logic [1:0]  rsp_err  [3];
  logic        ld_en;
  logic [3:0]  ld_addr;
  logic [31:0] ld_data;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t exp_q [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    imem_fetch #(.XLEN(32), .DEPTH(16), .LATENCY((g == 0) ? 1 : ((g == 1) ? 3 : 4))) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_addr(req_addr[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
      .rsp_data(rsp_data[g]), .rsp_addr(rsp_addr[g]), .rsp_err(rsp_err[g]),
      .flush(flush[g]), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    bit   seen;
    int   fcyc;
    exp_t em;
    initial begin
      seen = 0;
      fcyc = 0;
      forever begin
        @(negedge clk);
        #3;
        if (!rsp_valid[g]) seen = 0;
        else begin
          if (!seen) begin seen = 1; fcyc = cyc; end
          if (rsp_ready[g]) begin
            seen = 0;
            checks++;
            if (exp_q[g].size() == 0) begin
              failures++;
              $display("FAIL unexpected_rsp g%0d: got addr=%0h data=%0h err=%0b, want no response",
                       g, rsp_addr[g], rsp_data[g], rsp_err[g]);
            end else begin
              em = exp_q[g].pop_front();
              if (rsp_data[g] !== em.data || rsp_addr[g] !== em.addr ||
                  rsp_err[g] !== em.err || fcyc != em.cyc) begin
                failures++;
                $display("FAIL rsp g%0d: got data=%0h addr=%0h err=%0b cyc=%0d, want data=%0h addr=%0h err=%0b cyc=%0d",
                         g, rsp_data[g], rsp_addr[g], rsp_err[g], fcyc, em.data, em.addr, em.err, em.cyc);
              end
            end
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Presents a request until accepted; the expected response (if pushed) carries the
  // cycle on which rsp_valid must first be seen.
  task automatic issue(input int g, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] e, input bit push);
    int n = 0;
    req_valid[g] = 1'b1;
    req_addr[g]  = a;
    #1;
    while (!req_ready[g] && n < 50) begin @(negedge clk); #1; n++; end
    if (!req_ready[g]) chk("accept_timeout", 32'(req_ready[g]), 32'd1);
    else if (push) exp_q[g].push_back('{a, d, e, cyc + 1 + ((e == 2'b00) ? lat_of(g) - 1 : 0)});
    @(negedge clk);
  endtask

  task automatic wait_valid(input int g);
    int n = 0;
    #1;
    while (!rsp_valid[g] && n < 50) begin @(negedge clk); #1; n++; end
    chk("wait_valid", 32'(rsp_valid[g]), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 100) begin
      @(negedge clk); n++;
    end
    chk("drain_pending", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; rsp_ready = '1; flush = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    for (int g = 0; g < 3; g++) req_addr[g] = '0;
    repeat (2) @(negedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("reset_rsp_valid", 32'(rsp_valid[g]), 32'd0);
      chk("reset_rsp_data",  rsp_data[g], 32'd0);
      chk("reset_rsp_addr",  rsp_addr[g], 32'd0);
      chk("reset_rsp_err",   32'(rsp_err[g]), 32'd0);
      chk("reset_req_ready", 32'(req_ready[g]), 32'd1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    load(4'd0, 32'd15); load(4'd1, 32'd64); load(4'd2, 32'd89); load(4'd3, 32'd1);

    // Single fetch, LATENCY=1
    issue(0, 32'h8, 32'd89, 2'b00, 1);
    req_valid[0] = 1'b0;
    drain();

    // LATENCY=3 with 4 cycles of backpressure
    rsp_ready[1] = 1'b0;
    issue(1, 32'h4, 32'd64, 2'b00, 1);
    req_valid[1] = 1'b0;
    wait_valid(1);
    for (int i = 0; i < 4; i++) begin
      chk("bp_data",      rsp_data[1], 32'd64);
      chk("bp_addr",      rsp_addr[1], 32'h4);
      chk("bp_valid",     32'(rsp_valid[1]), 32'd1);
      chk("bp_req_ready", 32'(req_ready[1]), 32'd0);
      @(negedge clk); #1;
    end
    rsp_ready[1] = 1'b1;

    // Error responses take one cycle regardless of latency
    issue(1, 32'h6,  32'd0, 2'b01, 1);
    issue(1, 32'h40, 32'd0, 2'b10, 1);
    issue(1, 32'h41, 32'd0, 2'b11, 1);
    req_valid[1] = 1'b0;
    drain();

    // Back-to-back stream, LATENCY=1
    issue(0, 32'h0, 32'd15, 2'b00, 1);
    issue(0, 32'h4, 32'd64, 2'b00, 1);
    issue(0, 32'h8, 32'd89, 2'b00, 1);
    issue(0, 32'hC, 32'd1,  2'b00, 1);
    req_valid[0] = 1'b0;
    drain();

    // Flush in WAIT, LATENCY=4; a request held during flush must not be taken
    issue(2, 32'h0, 32'd15, 2'b00, 0);
    req_valid[2] = 1'b0;
    @(negedge clk);
    flush[2] = 1'b1;
    @(negedge clk);
    req_valid[2] = 1'b1; req_addr[2] = 32'h4;
    #1;
    chk("flush_req_ready", 32'(req_ready[2]), 32'd0);
    @(negedge clk);
    flush[2] = 1'b0; req_valid[2] = 1'b0;
    #1;
    chk("flush_rsp_valid", 32'(rsp_valid[2]), 32'd0);
    repeat (8) @(negedge clk);
    #1;
    chk("flush_no_rsp", 32'(rsp_valid[2]), 32'd0);
    issue(2, 32'hC, 32'd1, 2'b00, 1);
    req_valid[2] = 1'b0;
    drain();

    // Reset while a response is held
    rsp_ready[0] = 1'b0;
    issue(0, 32'h0, 32'd15, 2'b00, 1);
    req_valid[0] = 1'b0;
    wait_valid(0);
    void'(exp_q[0].pop_back());
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid",     32'(rsp_valid[0]), 32'd0);
    chk("rst_mid_data",      rsp_data[0], 32'd0);
    chk("rst_mid_addr",      rsp_addr[0], 32'd0);
    chk("rst_mid_err",       32'(rsp_err[0]), 32'd0);
    chk("rst_mid_req_ready", 32'(req_ready[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready[0] = 1'b1;
    issue(0, 32'h0, 32'd15, 2'b00, 1);

    // Load collision on the RESP-entry edge returns the old word
    ld_en = 1'b1; ld_addr = 4'd2; ld_data = 32'd73;
    issue(0, 32'h8, 32'd89, 2'b00, 1);
    ld_en = 1'b0;
    issue(0, 32'h8, 32'd73, 2'b00, 1);
    req_valid[0] = 1'b0;
    drain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_fetch.md
# imem_fetch

Parametrised, synchronous instruction memory with a valid/ready request/response handshake. It replaces the purely combinational instruction lookup with a byte-addressed, word-aligned fetch port that has programmable read latency, error reporting, a pipeline flush for branch redirects, and a load port for writing program contents. It sits between the fetch stage's PC logic and the decode stage.

## Interface
- `XLEN`, 32: instruction/address width in bits.
- `DEPTH`, 16: number of instruction words stored. Must be ≥ 2.
- `LATENCY`, 1: cycles from request acceptance to `rsp_valid`. Legal range 1..8.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  fetch request present.
- `req_ready`  out  1  block can accept a request this cycle.
- `req_addr`  in  XLEN  byte address of the requested instruction.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_data`  out  XLEN  instruction word. Forced to 0 on error.
- `rsp_addr`  out  XLEN  echo of the accepted `req_addr`.
- `rsp_err`  out  2  bit0 = misaligned, bit1 = out of range.
- `flush`  in  1  abort the in-flight fetch and any pending response.
- `ld_en`  in  1  write strobe for program load.
- `ld_addr`  in  $clog2(DEPTH)  word index to write.
- `ld_data`  in  XLEN  word to write.

## Operation
- Storage is an array of DEPTH × XLEN words. `rst_n` does not clear it. Unwritten words read as X.
- Load:
  - When `ld_en`=1 at an edge, `mem[ld_addr]` ← `ld_data`.
  - Loads to `ld_addr` ≥ DEPTH are ignored.
  - Loads are allowed in any state.
- Request acceptance: a request is accepted when `req_valid && req_ready` at an edge. At acceptance, `req_addr` is captured into `rsp_addr`.
- Error check, evaluated at acceptance:
  - misaligned = `req_addr[1:0]` != 0.
  - out of range = (`req_addr` >> 2) ≥ DEPTH.
  - Both error bits can be set together.
- State machine: IDLE, WAIT, RESP.
  - IDLE: `req_ready`=1.
    - On an accepted request with an error, go to RESP, with `rsp_data`=0 and `rsp_err` set.
    - On an accepted request with no error and LATENCY=1, go to RESP.
    - On an accepted request with no error and LATENCY>1, go to WAIT with the down-counter ← LATENCY−2.
  - WAIT: the counter decrements each cycle. When it reaches 0, go to RESP at the next edge.
  - RESP: `rsp_valid`=1. Outputs are held stable until `rsp_ready`=1.
    - On handshake without a new request, go to IDLE.
    - `req_ready` = `rsp_ready` in RESP, so a back-to-back request is accepted on the same edge as the response handshake and follows the IDLE acceptance rules.
- Data capture: `rsp_data` ← `mem[req_addr>>2]` on the edge that enters RESP.
  - If a load to the same word occurs on that same edge, the pre-write (old) value is returned.
  - Loads after RESP is entered do not change the held `rsp_data`.
- Flush:
  - `flush`=1 forces `req_ready`=0 that cycle.
  - Next state is IDLE from any state; the counter is cleared; the pending response is dropped.
  - Flush has priority over both the response handshake and acceptance.
  - A request presented during flush is not accepted and must be re-presented.
- Reset (`rst_n`=0): state → IDLE; counter → 0.
  - `req_ready`=1 during and after reset.
  - `rsp_valid`, `rsp_data`, `rsp_addr` and `rsp_err` are all 0.
  - Reset mid-operation discards the in-flight fetch with no response.

## Timing
- Good request accepted at edge N: `rsp_valid` is high starting at edge N+LATENCY.
- Error request accepted at edge N: `rsp_valid` is high starting at edge N+1, regardless of LATENCY.
- Maximum throughput:
  - LATENCY=1: one response per cycle when `rsp_ready` is held high.
  - Otherwise: one response per LATENCY cycles.
- `rsp_*` outputs are registered. `req_ready` is combinational from state, `rsp_ready` and `flush` only.
- `flush` takes effect at the next edge: `rsp_valid` is low in the cycle after the flush edge.

## Test plan
- **Load and fetch, LATENCY=1:** load `mem[0..3]` = 15, 64, 89, 1; request addr 0x8 with `rsp_ready`=1 → `rsp_valid` on the next cycle, `rsp_data`=89, `rsp_addr`=0x8, `rsp_err`=0.
- **Latency and backpressure, LATENCY=3:** request addr 0x4 at edge N → `rsp_valid` at N+3 with data 64. Hold `rsp_ready`=0 for 4 cycles → outputs stable and `req_ready`=0.
- **Errors:** request 0x6 → `rsp_err`=01, data 0 after 1 cycle. With DEPTH=16, request 0x40 → `rsp_err`=10. Request 0x41 → `rsp_err`=11.
- **Back-to-back, LATENCY=1:** stream requests 0x0, 0x4, 0x8, 0xC with `rsp_ready`=1 → four consecutive responses 15, 64, 89, 1 with no bubble.
- **Flush in WAIT, LATENCY=4:** assert `flush` 2 cycles after acceptance → no response ever appears for that request. Next request 0xC → data 1 after 4 cycles.
- **Reset mid-RESP and load collision:**
  - Drop `rst_n` while `rsp_valid`=1 → all `rsp_*` outputs 0 immediately, `req_ready`=1.
  - Memory contents survive reset: re-fetching 0x0 returns 15.
  - Load `mem[2]`=73 on the RESP-entry edge of a fetch to 0x8 → returns 89; the next fetch to 0x8 returns 73.
